// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rxState_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake and status bundle
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   modport master (
      output rx_data, rx_valid, frame_err, overrun, busy,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun, busy,
      output rx_ready
   );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line
// Resets to 1 so a line held in reset looks idle rather than like a start bit.
module uart_rx_sync (
   input  logic clk10m,
   input  logic rst_n,
   input  logic rxd,
   output logic rxdS
);

   logic meta;

   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         rxdS <= 1'b1;
      end else begin
         meta <= rxd;
         rxdS <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-byte ready/valid output stage
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic      clk10m,
   input  logic      rst_n,
   input  logic      rxd,
   uart_rx_if.master bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   rxState_t             state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bitIdx;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] rxData;
   logic                 rxValid;
   logic                 frameErr;
   logic                 overrunPulse;
   logic                 busyReg;
   logic                 rxdS;
   logic                 accept;

   uart_rx_sync uSync (
      .clk10m (clk10m),
      .rst_n  (rst_n),
      .rxd    (rxd),
      .rxdS   (rxdS)
   );

   assign accept = rxValid && bus.rx_ready;

   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bitIdx       <= '0;
         shiftReg     <= '0;
         rxData       <= '0;
         rxValid      <= 1'b0;
         frameErr     <= 1'b0;
         overrunPulse <= 1'b0;
         busyReg      <= 1'b0;
      end else begin
         frameErr     <= 1'b0;
         overrunPulse <= 1'b0;
         // A completing frame below may re-set rxValid in the same cycle.
         if (accept) begin
            rxValid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxdS) begin
                  state   <= START;
                  cnt     <= '0;
                  busyReg <= 1'b1;
               end
            end

            START: begin
               if (cnt == HALF_CNT) begin
                  cnt <= '0;
                  if (!rxdS) begin
                     state  <= DATA;
                     bitIdx <= '0;
                  end else begin
                     state   <= IDLE;
                     busyReg <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == LAST_CNT) begin
                  cnt              <= '0;
                  shiftReg[bitIdx] <= rxdS;
                  if (bitIdx == LAST_IDX) begin
                     state <= STOP;
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (rxdS) begin
                     state   <= IDLE;
                     busyReg <= 1'b0;
                     if (!rxValid || bus.rx_ready) begin
                        rxData  <= shiftReg;
                        rxValid <= 1'b1;
                     end else begin
                        overrunPulse <= 1'b1;
                     end
                  end else begin
                     state    <= BREAK;
                     frameErr <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            BREAK: begin
               if (rxdS) begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end
            end

            default: begin
               state   <= IDLE;
               busyReg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_data   = rxData;
   assign bus.rx_valid  = rxValid;
   assign bus.frame_err = frameErr;
   assign bus.overrun   = overrunPulse;
   assign bus.busy      = busyReg;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 87 and 4 clocks per bit
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB_A = 87;
   localparam int CPB_B = 4;

   logic clk10m = 1'b0;
   logic rst_n  = 1'b0;
   logic rxdA   = 1'b1;
   logic rxdB   = 1'b1;

   always #5 clk10m = ~clk10m;

   uart_rx_if busA ();
   uart_rx_if busB ();

   uart_rx #(.CLKS_PER_BIT(CPB_A)) dutA (
      .clk10m (clk10m),
      .rst_n  (rst_n),
      .rxd    (rxdA),
      .bus    (busA.master)
   );

   uart_rx #(.CLKS_PER_BIT(CPB_B)) dutB (
      .clk10m (clk10m),
      .rst_n  (rst_n),
      .rxd    (rxdB),
      .bus    (busB.master)
   );

   int nVectors     = 0;
   int nMiscompares = 0;

   logic [7:0] qA[$];
   logic [7:0] qB[$];

   int validCyclesA = 0;
   int frameErrA    = 0;
   int overrunA     = 0;
   int frameErrB    = 0;
   int overrunB     = 0;
   int rxCountB     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk10m) begin
      if (busA.rx_valid)  validCyclesA++;
      if (busA.frame_err) frameErrA++;
      if (busA.overrun)   overrunA++;
      if (busA.rx_valid && busA.rx_ready) begin
         if (qA.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("FAIL rxA_unexpected: got 0x%0h, expected no byte", busA.rx_data);
         end else begin
            check("rxA_byte", 32'(busA.rx_data), 32'(qA.pop_front()));
         end
      end
   end

   always @(negedge clk10m) begin
      if (busB.frame_err) frameErrB++;
      if (busB.overrun)   overrunB++;
      if (busB.rx_valid && busB.rx_ready) begin
         rxCountB++;
         if (qB.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("FAIL rxB_unexpected: got 0x%0h, expected no byte", busB.rx_data);
         end else begin
            check("rxB_byte", 32'(busB.rx_data), 32'(qB.pop_front()));
         end
      end
   end

   task automatic driveBit(input bit sel, input logic v, input int n);
      if (sel) rxdB = v;
      else     rxdA = v;
      repeat (n) @(negedge clk10m);
   endtask

   task automatic sendFrame(input bit sel, input logic [7:0] b);
      int cpb;
      cpb = sel ? CPB_B : CPB_A;
      driveBit(sel, 1'b0, cpb);
      for (int i = 0; i < 8; i++) driveBit(sel, b[i], cpb);
      driveBit(sel, 1'b1, cpb);
   endtask

   task automatic setReadyA(input logic v);
      @(posedge clk10m);
      #2 busA.rx_ready = v;
      @(negedge clk10m);
   endtask

   initial begin
      int v0, fe0, ov0;
      logic [7:0] b;
      logic [7:0] partial;

      busA.rx_ready = 1'b0;
      busB.rx_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk10m);
      check("rst_rx_data",   32'(busA.rx_data),   32'h0);
      check("rst_rx_valid",  32'(busA.rx_valid),  32'h0);
      check("rst_frame_err", 32'(busA.frame_err), 32'h0);
      check("rst_overrun",   32'(busA.overrun),   32'h0);
      check("rst_busy",      32'(busA.busy),      32'h0);
      check("rst_busyB",     32'(busB.busy),      32'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk10m);

      // Single byte with consumer always ready
      setReadyA(1'b1);
      v0  = validCyclesA;
      fe0 = frameErrA;
      qA.push_back(8'h55);
      sendFrame(1'b0, 8'h55);
      driveBit(1'b0, 1'b1, 20);
      check("t55_valid_cycles", 32'(validCyclesA - v0), 32'd1);
      check("t55_frame_err",    32'(frameErrA - fe0),   32'd0);
      check("t55_drained",      32'(qA.size()),         32'd0);

      // Back-to-back frames while consumer stalls: second byte overruns
      setReadyA(1'b0);
      ov0 = overrunA;
      qA.push_back(8'hA3);
      sendFrame(1'b0, 8'hA3);
      sendFrame(1'b0, 8'h0F);
      driveBit(1'b0, 1'b1, 10);
      check("ovr_pulses",   32'(overrunA - ov0),    32'd1);
      check("ovr_valid",    32'(busA.rx_valid),     32'h1);
      check("ovr_rx_data",  32'(busA.rx_data),      32'hA3);
      setReadyA(1'b1);
      repeat (5) @(negedge clk10m);
      check("ovr_drained",  32'(qA.size()),         32'd0);
      check("ovr_valid_clr",32'(busA.rx_valid),     32'h0);

      // Short low glitch is rejected by the mid-start sample
      v0 = validCyclesA;
      driveBit(1'b0, 1'b0, 20);
      check("glitch_busy_hi", 32'(busA.busy), 32'h1);
      driveBit(1'b0, 1'b1, 80);
      check("glitch_busy_lo", 32'(busA.busy), 32'h0);
      check("glitch_no_valid",32'(validCyclesA - v0), 32'd0);

      // Stop bit held low: one frame error, busy until line idles
      v0  = validCyclesA;
      fe0 = frameErrA;
      driveBit(1'b0, 1'b0, CPB_A);
      for (int i = 0; i < 8; i++) driveBit(1'b0, 1'b1, CPB_A);
      driveBit(1'b0, 1'b0, 200);
      check("brk_frame_err",  32'(frameErrA - fe0), 32'd1);
      check("brk_busy_hi",    32'(busA.busy),       32'h1);
      driveBit(1'b0, 1'b0, 100);
      driveBit(1'b0, 1'b1, 10);
      check("brk_busy_lo",    32'(busA.busy),       32'h0);
      check("brk_frame_err1", 32'(frameErrA - fe0), 32'd1);
      check("brk_no_valid",   32'(validCyclesA - v0), 32'd0);

      // Reset mid-frame during data bit 4 of 0x3C, then a clean 0x81
      fe0 = frameErrA;
      ov0 = overrunA;
      partial = 8'h3C;
      driveBit(1'b0, 1'b0, CPB_A);
      for (int i = 0; i < 4; i++) driveBit(1'b0, partial[i], CPB_A);
      driveBit(1'b0, partial[4], 40);
      rst_n = 1'b0;
      repeat (3) @(negedge clk10m);
      check("mid_rst_rx_data",  32'(busA.rx_data),  32'h0);
      check("mid_rst_rx_valid", 32'(busA.rx_valid), 32'h0);
      check("mid_rst_busy",     32'(busA.busy),     32'h0);
      rst_n = 1'b1;
      driveBit(1'b0, 1'b1, 20);
      check("post_rst_busy",    32'(busA.busy),     32'h0);
      v0 = validCyclesA;
      qA.push_back(8'h81);
      sendFrame(1'b0, 8'h81);
      driveBit(1'b0, 1'b1, 20);
      check("post_rst_drained",   32'(qA.size()),          32'd0);
      check("post_rst_valid_cyc", 32'(validCyclesA - v0),  32'd1);
      check("post_rst_frame_err", 32'(frameErrA - fe0),    32'd0);
      check("post_rst_overrun",   32'(overrunA - ov0),     32'd0);

      // 256 back-to-back random bytes at the minimum bit period
      for (int n = 0; n < 256; n++) begin
         b = 8'($urandom_range(0, 255));
         qB.push_back(b);
         sendFrame(1'b1, b);
      end
      driveBit(1'b1, 1'b1, 20);
      check("fast_count",     32'(rxCountB),  32'd256);
      check("fast_drained",   32'(qB.size()), 32'd0);
      check("fast_frame_err", 32'(frameErrB), 32'd0);
      check("fast_overrun",   32'(overrunB),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
